block_average_scaler: RTL
=========================

# block_average_scaler

Sequential, parametrised block-averaging downscaler for the processing path. On `start` it walks the source frame in raster order of output pixels and, for each output pixel, fetches a 2^s × 2^s block from source memory over a one-cycle-latency read port. It accumulates the block, divides by the block size, and presents the mean on a valid/ready output stream. It is the successor of the combinational block averager: arbitrary frame size, pixel width and shift up to `MAX_SHIFT`, with real memory sequencing and backpressure.

## Interface
- `IMG_WIDTH`, 160: source width in pixels; must be divisible by 2^MAX_SHIFT.
- `IMG_HEIGHT`, 120: source height in pixels; must be divisible by 2^MAX_SHIFT.
- `PIXEL_W`, 8: pixel width in bits.
- `ADDR_W`, 15: source address width; must satisfy 2^ADDR_W ≥ IMG_WIDTH·IMG_HEIGHT.
- `MAX_SHIFT`, 2: largest log2 block edge.
- `ROUND`, 0: 0 truncates the mean; 1 adds 2^(2s-1) before the shift (only when s>0).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to process a frame.
- `shift` in 2: log2 block edge s, sampled on an accepted `start`; values above MAX_SHIFT are clamped to MAX_SHIFT.
- `mem_ren` out 1: read strobe.
- `mem_raddr` out ADDR_W: read address, row-major (y·IMG_WIDTH + x).
- `mem_rdata` in PIXEL_W: read data, valid exactly one cycle after the `mem_ren` cycle.
- `out_valid` out 1: output pixel valid.
- `out_ready` in 1: sink accepts the pixel.
- `out_pixel` out PIXEL_W: block mean.
- `out_x` out 10, `out_y` out 10: output-pixel coordinates.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at the end of the frame.

## Operation
- States are IDLE, FETCH, DRAIN, OUT and DONE.
- IDLE: when `start`=1, latch the clamped s, clear the block origin (bx,by)=(0,0) and (dx,dy)=(0,0), and go to FETCH. `start` is ignored in every other state.
- FETCH: each cycle assert `mem_ren` with address (by·2^s+dy)·IMG_WIDTH + (bx·2^s+dx). Advance dx, then dy (row-major within the block). Each cycle, accumulate the `mem_rdata` belonging to the previous cycle's read. After the 2^(2s)-th read, go to DRAIN.
- DRAIN: no read is issued. Accumulate the final datum, then go to OUT.
- OUT: `out_pixel` = (sum + rnd) >> 2s, where rnd = 2^(2s-1) if ROUND=1 and s>0, otherwise 0. Hold `out_valid`=1 with `out_pixel`, `out_x`=bx and `out_y`=by stable until `out_ready`=1.
  - On acceptance, clear the accumulator and advance bx. Wrap bx at IMG_WIDTH>>s and then advance by.
  - Go to FETCH for the next block, or to DONE if the accepted block was the last one (bx = (IMG_WIDTH>>s)−1 and by = (IMG_HEIGHT>>s)−1).
- DONE: `done`=1 for one cycle, then IDLE.
- Accumulator width is PIXEL_W+2·MAX_SHIFT+1 bits, with no overflow for any input. The result is truncated to PIXEL_W bits and never exceeds 2^PIXEL_W−1.
- s=0 is pass-through: `out_pixel` equals the source pixel.
- Output dimensions are (IMG_WIDTH>>s) × (IMG_HEIGHT>>s).

## Timing
- Reset: while `reset_n`=0 at a clock edge, the state goes to IDLE and the accumulator is cleared. From the next cycle, `mem_ren`, `out_valid`, `busy` and `done` are 0, and `mem_raddr`, `out_pixel`, `out_x` and `out_y` are 0. Reset mid-frame abandons the frame without asserting `done`.
- If `start` is sampled at edge t, the first `mem_ren` is high in cycle t+1.
- Per block: 2^(2s) FETCH cycles, 1 DRAIN cycle, and at least 1 OUT cycle. With `out_ready` held high, the block period is 2^(2s)+2 cycles.
- Full frame with `out_ready` always high: (IMG_WIDTH·IMG_HEIGHT/4^s)·(4^s+2) cycles from the first `mem_ren` to the last acceptance. `done` is asserted in the cycle after the last acceptance.
- Backpressure: `mem_ren` is 0 throughout OUT, so no reads are issued while stalled.
- Outputs are registered. `out_ready` may be high before `out_valid`; it is only sampled in OUT.

## Test plan
- Ramp memory (`mem_rdata` = addr[7:0]), defaults, s=1, ROUND=0, `out_ready`=1. First block reads addresses 0, 1, 160 and 161 → `out_pixel`=80 at (0,0). The frame produces 4800 pixels, `done` is asserted 28800 cycles after the first `mem_ren`, and `out_x` spans 0..79 and `out_y` spans 0..59.
- Same stimulus with ROUND=1 → first pixel is 81.
- Ramp memory, `shift`=3 (clamped to 2) → 16 reads per block; the first block sum is 1816 → `out_pixel`=113; output is 40×30 pixels.
- s=0 with random memory → the output stream equals memory in address order; 19200 pixels; block period 3 cycles.
- With s=1, hold `out_ready` low for 10 cycles on block 5 → `out_pixel`, `out_x` and `out_y` stay stable, `mem_ren` stays 0, and there is no lost or duplicated pixel. A `start` pulse mid-frame is ignored.
- Drive `reset_n`=0 for 1 cycle during FETCH of block 100 → next cycle all outputs are 0 and `busy`=0 with no `done` pulse. A new `start` restarts at (0,0) and the first address is 0.

Source files
------------

// File: rtl/block_average_scaler.sv
// Sequential block-averaging downscaler: fetches 2^s x 2^s source blocks over a
// one-cycle-latency read port and streams the block means with valid/ready.
module block_average_scaler #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int PIXEL_W    = 8,
  parameter int ADDR_W     = 15,
  parameter int MAX_SHIFT  = 2,
  parameter int ROUND      = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         shift,
  output logic               mem_ren,
  output logic [ADDR_W-1:0]  mem_raddr,
  input  logic [PIXEL_W-1:0] mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIXEL_W-1:0] out_pixel,
  output logic [9:0]         out_x,
  output logic [9:0]         out_y,
  output logic               busy,
  output logic               done
);
  localparam int AW = PIXEL_W + 2*MAX_SHIFT + 1;
  localparam int CW = 2*MAX_SHIFT + 1;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, DONE} state_t;

  state_t        state;
  logic [1:0]    s;
  logic [CW-1:0] cnt;
  logic [9:0]    bx, by;
  logic [AW-1:0] acc;
  logic          pend;

  logic [1:0]    s_clamp;
  logic [AW-1:0] acc_in, rnd, mean;
  logic [CW-1:0] last_k;
  logic [9:0]    bx_last, by_last, nbx, nby;
  logic          blk_last;

  // Address of the k-th pixel (row-major) inside block (x,y) at block edge 2^sh.
  function automatic logic [ADDR_W-1:0] blk_addr(input logic [9:0] x, input logic [9:0] y,
                                                 input logic [CW-1:0] k, input logic [1:0] sh);
    logic [31:0] kk, row, col;
    kk  = 32'(k);
    col = (32'(x) << sh) + (kk & ((32'd1 << sh) - 32'd1));
    row = (32'(y) << sh) + (kk >> sh);
    return ADDR_W'(row * 32'(IMG_WIDTH) + col);
  endfunction

  always_comb begin
    s_clamp  = (32'(shift) > MAX_SHIFT) ? 2'(MAX_SHIFT) : shift;
    // pend marks that last cycle issued a read, so mem_rdata belongs to this block
    acc_in   = acc + (pend ? AW'(mem_rdata) : '0);
    rnd      = '0;
    if (ROUND != 0 && s != 2'd0) rnd = AW'(1) << (2*s - 1);
    mean     = (acc_in + rnd) >> (2*s);
    last_k   = CW'((1 << (2*s)) - 1);
    bx_last  = 10'((IMG_WIDTH >> s) - 1);
    by_last  = 10'((IMG_HEIGHT >> s) - 1);
    blk_last = (bx == bx_last) && (by == by_last);
    nbx      = (bx == bx_last) ? 10'd0 : bx + 10'd1;
    nby      = (bx == bx_last) ? by + 10'd1 : by;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      s         <= '0;
      cnt       <= '0;
      bx        <= '0;
      by        <= '0;
      acc       <= '0;
      pend      <= 1'b0;
      mem_ren   <= 1'b0;
      mem_raddr <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_x     <= '0;
      out_y     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pend <= mem_ren;
      case (state)
        IDLE: if (start) begin
          s         <= s_clamp;
          bx        <= '0;
          by        <= '0;
          cnt       <= '0;
          acc       <= '0;
          mem_ren   <= 1'b1;
          mem_raddr <= '0;
          busy      <= 1'b1;
          state     <= FETCH;
        end
        FETCH: begin
          acc <= acc_in;
          if (cnt == last_k) begin
            mem_ren <= 1'b0;
            state   <= DRAIN;
          end else begin
            cnt       <= cnt + 1'b1;
            mem_raddr <= blk_addr(bx, by, cnt + 1'b1, s);
          end
        end
        DRAIN: begin
          acc       <= acc_in;
          out_pixel <= mean[PIXEL_W-1:0];
          out_x     <= bx;
          out_y     <= by;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          acc       <= '0;
          bx        <= nbx;
          by        <= nby;
          cnt       <= '0;
          if (blk_last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            mem_ren   <= 1'b1;
            mem_raddr <= blk_addr(nbx, nby, '0, s);
            state     <= FETCH;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
